// File: rtl/legv8_fetch_stage.sv
// LEGv8 instruction-fetch stage: holds the PC, issues single-cycle valid/ack
// reads to instruction memory and buffers one fetched word for the decoder.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction memory read handshake
//   instr_bus/pc/valid         buffered word for the decoder, its PC, valid flag
//   decode_ready               decoder consumes the buffered word this cycle
//   branch_taken/target        single-cycle redirect request and target
//   halt                       level, suspends new fetches
//   fault                      sticky misaligned-redirect flag
//   fetch_count                saturating count of completed memory transfers
module legv8_fetch_stage #(
  parameter int unsigned      PC_W     = 64,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter int unsigned      CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_bus,
  output logic [PC_W-1:0]  instr_pc,
  output logic             instr_valid,
  input  logic             decode_ready,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned INSTR_W = 32;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_bus_q, instr_bus_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic slot_free_c;
  logic req_c;
  logic xfer_c;

  // Request is combinational so a zero-latency memory sustains one word/cycle.
  always_comb begin
    slot_free_c = !instr_valid_q || decode_ready;
    req_c       = (state_q == ST_RUN) && slot_free_c && !branch_taken && !halt;
    xfer_c      = req_c && imem_ack;
  end

  // Next-state logic for control state, PC, output buffer and counters.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_bus_d   = instr_bus_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN, ST_HALTED: begin
        if (branch_taken) begin
          // Redirect squashes the buffered word and wins over everything else.
          instr_valid_d = 1'b0;
          pc_d          = branch_target;
          if (branch_target[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
        end else begin
          if (xfer_c) begin
            instr_bus_d   = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_W'(4);
            if (fetch_count_q != '1) begin
              fetch_count_d = fetch_count_q + CNT_W'(1);
            end
          end else if (instr_valid_q && decode_ready) begin
            instr_valid_d = 1'b0;
          end

          if (state_q == ST_RUN && halt) begin
            state_d = ST_HALTED;
          end else if (state_q == ST_HALTED && !halt) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_FAULT: begin
        instr_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      instr_bus_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_bus_q   <= instr_bus_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = req_c;
  assign imem_addr   = pc_q;
  assign instr_bus   = instr_bus_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_legv8_fetch_stage.sv
// Directed bench for legv8_fetch_stage: a default instance exercises fetch,
// stall, redirect, halt and fault; a second instance starts at the top of the
// address space with a 2-bit counter to cover PC wrap and count saturation.
module tb_legv8_fetch_stage;

  logic        clk;
  logic        rst_n;

  // Default instance signals.
  logic        imem_req, imem_ack, instr_valid, decode_ready;
  logic        branch_taken, halt, fault;
  logic [63:0] imem_addr, instr_pc, branch_target;
  logic [31:0] imem_rdata, instr_bus;
  logic [31:0] fetch_count;

  // Wrap/saturation instance signals.
  logic        w_req, w_ack, w_valid, w_ready, w_branch, w_halt, w_fault;
  logic [63:0] w_addr, w_pc, w_target;
  logic [31:0] w_rdata, w_bus;
  logic [1:0]  w_count;

  int n_checks = 0;
  int n_err    = 0;

  // Instruction memory contents: two fixed words, otherwise tagged by address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'd0)      return 32'h8B02_0020;
    else if (a == 64'd4) return 32'h9100_0421;
    else                 return {16'hD503, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  legv8_fetch_stage u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_bus     (instr_bus),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  legv8_fetch_stage #(
    .PC_W     (64),
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC),
    .CNT_W    (2)
  ) u_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .instr_bus     (w_bus),
    .instr_pc      (w_pc),
    .instr_valid   (w_valid),
    .decode_ready  (w_ready),
    .branch_taken  (w_branch),
    .branch_target (w_target),
    .halt          (w_halt),
    .fault         (w_fault),
    .fetch_count   (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b1; decode_ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    w_ack = 1'b1; w_ready = 1'b1; w_branch = 1'b0; w_target = '0; w_halt = 1'b0;

    // Reset state.
    #12;
    chk("rst_req",   64'(imem_req),    64'd0);
    chk("rst_bus",   64'(instr_bus),   64'd0);
    chk("rst_ipc",   instr_pc,         64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_fault", 64'(fault),       64'd0);
    chk("rst_cnt",   64'(fetch_count), 64'd0);
    chk("rst_addr",  imem_addr,        64'd0);
    chk("w_rst_addr", w_addr,          64'hFFFF_FFFF_FFFF_FFFC);

    // Release away from the rising edge; first cycle is BOOT with no request.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_req", 64'(imem_req), 64'd0);
    step();                                        // E1: BOOT -> RUN
    chk("run_req",  64'(imem_req), 64'd1);
    chk("run_addr", imem_addr,     64'd0);
    chk("w_run_req", 64'(w_req),   64'd1);
    step();                                        // E2: transfer @0
    chk("f0_bus",   64'(instr_bus),   64'h8B02_0020);
    chk("f0_ipc",   instr_pc,         64'd0);
    chk("f0_valid", 64'(instr_valid), 64'd1);
    chk("f0_cnt",   64'(fetch_count), 64'd1);
    chk("f0_addr",  imem_addr,        64'd4);
    chk("w_top_ipc", w_pc,            64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_top_bus", 64'(w_bus),      64'hD503_FFFC);
    chk("w_wrap_addr", w_addr,        64'd0);
    chk("w_cnt1",   64'(w_count),     64'd1);
    step();                                        // E3: transfer @4
    chk("f4_bus",   64'(instr_bus),   64'h9100_0421);
    chk("f4_ipc",   instr_pc,         64'd4);
    chk("f4_cnt",   64'(fetch_count), 64'd2);
    chk("w_zero_ipc", w_pc,           64'd0);
    chk("w_zero_bus", 64'(w_bus),     64'h8B02_0020);
    chk("w_cnt2",   64'(w_count),     64'd2);

    // Decoder stall for three cycles: no requests, buffer and PC hold.
    decode_ready = 1'b0;
    #1;
    chk("stall_req", 64'(imem_req), 64'd0);
    step();                                        // E4
    chk("w_cnt3",   64'(w_count), 64'd3);
    step();                                        // E5
    chk("w_sat",    64'(w_count), 64'd3);
    step();                                        // E6
    chk("stall_bus",  64'(instr_bus),   64'h9100_0421);
    chk("stall_addr", imem_addr,        64'd8);
    chk("stall_cnt",  64'(fetch_count), 64'd2);
    chk("stall_req2", 64'(imem_req),    64'd0);
    decode_ready = 1'b1;
    #1;
    chk("unstall_req", 64'(imem_req), 64'd1);
    step();                                        // E7: transfer @8
    chk("f8_bus", 64'(instr_bus),   64'hD503_0008);
    chk("f8_ipc", instr_pc,         64'd8);
    chk("f8_cnt", 64'(fetch_count), 64'd3);

    // Aligned redirect with ack high: word squashed, ack ignored.
    branch_taken = 1'b1; branch_target = 64'h100;
    #1;
    chk("br_req", 64'(imem_req), 64'd0);
    step();                                        // E8
    branch_taken = 1'b0;
    #1;
    chk("br_valid", 64'(instr_valid), 64'd0);
    chk("br_addr",  imem_addr,        64'h100);
    chk("br_cnt",   64'(fetch_count), 64'd3);
    chk("br_req2",  64'(imem_req),    64'd1);
    step();                                        // E9: transfer @0x100
    chk("f100_bus", 64'(instr_bus),   64'hD503_0100);
    chk("f100_ipc", instr_pc,         64'h100);
    chk("f100_cnt", 64'(fetch_count), 64'd4);

    // Halt for four cycles; buffered word drains while halted.
    halt = 1'b1; decode_ready = 1'b0;
    #1;
    chk("halt_req", 64'(imem_req), 64'd0);
    step();                                        // E10: RUN -> HALTED
    chk("halt_valid", 64'(instr_valid), 64'd1);
    decode_ready = 1'b1;
    step();                                        // E11: consume
    chk("drain_valid", 64'(instr_valid), 64'd0);
    chk("drain_req",   64'(imem_req),    64'd0);
    step();                                        // E12
    step();                                        // E13
    chk("halt_addr", imem_addr,        64'h104);
    chk("halt_cnt",  64'(fetch_count), 64'd4);
    halt = 1'b0;
    #1;
    chk("unhalt_req0", 64'(imem_req), 64'd0);
    step();                                        // E14: HALTED -> RUN
    chk("resume_req",  64'(imem_req), 64'd1);
    chk("resume_addr", imem_addr,     64'h104);
    step();                                        // E15: transfer @0x104
    chk("f104_bus", 64'(instr_bus),   64'hD503_0104);
    chk("f104_cnt", 64'(fetch_count), 64'd5);

    // Misaligned redirect: sticky fault, no further requests or redirects.
    branch_taken = 1'b1; branch_target = 64'h102;
    step();                                        // E16
    branch_taken = 1'b0;
    #1;
    chk("flt_fault", 64'(fault),       64'd1);
    chk("flt_req",   64'(imem_req),    64'd0);
    chk("flt_valid", 64'(instr_valid), 64'd0);
    chk("flt_addr",  imem_addr,        64'h102);
    branch_taken = 1'b1; branch_target = 64'h200;
    step();                                        // E17
    branch_taken = 1'b0;
    step();
    chk("flt_br_ign", imem_addr,     64'h102);
    chk("flt_sticky", 64'(fault),    64'd1);
    chk("flt_req2",   64'(imem_req), 64'd0);

    // Mid-operation asynchronous reset, asserted away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fault", 64'(fault),       64'd0);
    chk("arst_cnt",   64'(fetch_count), 64'd0);
    chk("arst_bus",   64'(instr_bus),   64'd0);
    chk("arst_addr",  imem_addr,        64'd0);
    chk("arst_req",   64'(imem_req),    64'd0);
    chk("w_arst_cnt", 64'(w_count),     64'd0);
    chk("w_arst_req", 64'(w_req),       64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
